// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
// Pure declarations: no logic, no latency, no flow control.
package seq_det_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam logic [PAT_W_DEF-1:0] PAT_RESET_DEF = 4'b1101;

    // Length 0 makes no sense as a pattern, so it is treated as a single-bit pattern.
    function automatic int clamp_len(input int len, input int max_len);
        int r;
        r = len;
        if (len < 1) begin
            r = 1;
        end else if (len > max_len) begin
            r = max_len;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_next.sv
// KMP next-state function for the pattern detector: longest pattern prefix ending at x.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] state,
    input  logic             overlap,
    input  logic             x,
    output logic [LEN_W-1:0] next_state,
    output logic             accept
);

    localparam int IDX_W = $clog2(PAT_W);

    logic [LEN_W-1:0] s_eff;
    logic             ok;
    logic [IDX_W-1:0] idx;

    // Candidate k qualifies when x == pat[k-1] and pat[s_eff-k+1 +: k-1] == pat[k-2:0].
    always_comb begin
        s_eff      = (state == len && !overlap) ? '0 : state;
        next_state = '0;
        ok         = 1'b0;
        idx        = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            ok = (k <= int'(len)) && (k <= int'(s_eff) + 1) && (x == pat[k-1]);
            for (int j = 0; j < PAT_W - 1; j++) begin
                if (ok && j < k - 1) begin
                    idx = IDX_W'(int'(s_eff) - k + 1 + j);
                    if (pat[idx] != pat[j]) begin
                        ok = 1'b0;
                    end
                end
            end
            if (ok) begin
                next_state = LEN_W'(k);
            end
        end
    end

    assign accept = (next_state == len);

endmodule

// File: rtl/moore_seq_detector.sv
// Programmable Moore sequence detector with overlap control; optional match counter (SEQ_DET_MATCH_CNT_EN).
// Latency: match rises one cycle after the final pattern bit. Backpressure: none, x_valid=0 holds all state.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = PAT_W_DEF,
    parameter int               LEN_W     = $clog2(PAT_W + 1),
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(PAT_RESET_DEF),
    parameter int               CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic [LEN_W-1:0] state,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic [LEN_W-1:0] state_q;
    logic [LEN_W-1:0] next_state;
    logic             accept;

    seq_det_next #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_next (
        .pat        (pat_q),
        .len        (len_q),
        .state      (state_q),
        .overlap    (overlap_q),
        .x          (x),
        .next_state (next_state),
        .accept     (accept)
    );

    // A config load restarts the search and drops any bit presented alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= PAT_RESET;
            len_q     <= LEN_W'(PAT_W);
            overlap_q <= 1'b1;
            state_q   <= '0;
        end else if (cfg_load) begin
            pat_q     <= cfg_pat;
            len_q     <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            overlap_q <= cfg_overlap;
            state_q   <= '0;
        end else if (x_valid) begin
            state_q   <= next_state;
        end
    end

    assign state = state_q;
    assign match = (state_q == len_q);

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (x_valid && !cfg_load && accept && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic cnt_unused;

    assign cnt_unused = cnt_clr ^ accept;
    assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Randomised and directed bench for moore_seq_detector against a suffix-matching reference model.
module tb_moore_seq_detector;

    localparam int PAT_W = 4;
    localparam int LEN_W = 3;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             x_valid;
    logic             x;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic [LEN_W-1:0] state, state2;
    logic             match, match2;
    logic [7:0]       match_cnt;
    logic [1:0]       match_cnt2;

    always #5 clk = ~clk;

    moore_seq_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .state(state), .match(match), .match_cnt(match_cnt)
    );

    moore_seq_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .state(state2), .match(match2), .match_cnt(match_cnt2)
    );

    // Reference model: keep the recent bit history and find the longest suffix equal to a pattern prefix.
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_state;
    int               m_cnt, m_cnt2;
    bit               hist[$];

    int checks = 0;
    int errors = 0;

    function automatic int clampl(input int l);
        return (l < 1) ? 1 : ((l > PAT_W) ? PAT_W : l);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 4'b1101; m_len = PAT_W; m_ovl = 1'b1; m_state = 0;
        m_cnt = 0; m_cnt2 = 0; hist.delete();
    endtask

    task automatic model_edge();
        bit ok;
        if (cfg_load) begin
            m_pat = cfg_pat; m_len = clampl(int'(cfg_len)); m_ovl = cfg_overlap;
            m_state = 0; hist.delete();
        end else if (x_valid) begin
            if (!m_ovl && m_state == m_len) hist.delete();
            hist.push_back(x);
            if (hist.size() > PAT_W) void'(hist.pop_front());
            m_state = 0;
            for (int k = 1; k <= m_len && k <= hist.size(); k++) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (hist[hist.size() - k + j] != m_pat[j]) ok = 1'b0;
                if (ok) m_state = k;
            end
            if (m_state == m_len) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        if (cnt_clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end
    endtask

    task automatic check_all();
        check("state", 32'(state), 32'(m_state));
        check("match", 32'(match), 32'(m_state == m_len));
        check("match_cnt", 32'(match_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
        check("state_w2", 32'(state2), 32'(m_state));
        check("match_cnt_w2", 32'(match_cnt2), CNT_EN ? 32'(m_cnt2) : 32'd0);
    endtask

    // Inputs change only here, one time unit after the edge, so they are stable at every sample.
    task automatic step(input logic v, input logic b);
        x_valid = v; x = b;
        @(posedge clk);
        model_edge();
        #1;
        x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        check_all();
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_load = 1'b1; cfg_pat = p; cfg_len = l; cfg_overlap = o;
        step(1'b0, 1'b0);
    endtask

    task automatic seq(input string tag, input int n, input logic [15:0] bits, input logic [31:0] exps);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[i]);
            check(tag, 32'(state), 32'(exps[4*i +: 4]));
        end
    endtask

    initial begin
        rst = 1'b1; x_valid = 1'b0; x = 1'b0; cfg_load = 1'b0; cfg_pat = '0;
        cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        check("reset_state", 32'(state), 32'd0);
        check("reset_match", 32'(match), 32'd0);
        check("reset_cnt", 32'(match_cnt), 32'd0);
        rst = 1'b0;

        // Default pattern 1101, overlap on.
        seq("ovl_1101", 7, 16'h006D, 32'h04324321);
        check("ovl_1101_cnt", 32'(match_cnt), CNT_EN ? 32'd2 : 32'd0);

        load(4'b1101, 3'd4, 1'b0);
        seq("novl_1101", 7, 16'h006D, 32'h01104321);
        check("novl_1101_cnt", 32'(match_cnt), CNT_EN ? 32'd3 : 32'd0);

        load(4'b0011, 3'd2, 1'b1);
        seq("ovl_11", 4, 16'h000F, 32'h00002221);
        load(4'b0011, 3'd2, 1'b0);
        seq("novl_11", 4, 16'h000F, 32'h00002121);
        check("pat11_cnt", 32'(match_cnt), CNT_EN ? 32'd8 : 32'd0);

        // Gaps mid-pattern and while matched.
        load(4'b1101, 3'd4, 1'b1);
        seq("gap_pre", 2, 16'h0001, 32'h00000021);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom));
            check("gap_hold", 32'(state), 32'd2);
        end
        seq("gap_post", 2, 16'h0003, 32'h00000043);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom));
            check("gap_match_hold", 32'(match), 32'd1);
        end

        // Load colliding with a valid bit that would otherwise complete the pattern.
        seq("coll_pre", 3, 16'h0005, 32'h00000321);
        cfg_load = 1'b1; cfg_pat = 4'b1101; cfg_len = 3'd4; cfg_overlap = 1'b1;
        step(1'b1, 1'b1);
        check("coll_state", 32'(state), 32'd0);
        seq("coll_post", 1, 16'h0001, 32'h00000001);

        // Async reset at state 3 with five matches counted, then the default pattern must work again.
        load(4'b0011, 3'd2, 1'b1);
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        seq("cnt5", 6, 16'h003F, 32'h00222221);
        check("cnt5_cnt", 32'(match_cnt), CNT_EN ? 32'd5 : 32'd0);
        load(4'b1101, 3'd4, 1'b1);
        seq("arst_pre", 3, 16'h0005, 32'h00000321);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_state", 32'(state), 32'd0);
        check("arst_match", 32'(match), 32'd0);
        check("arst_cnt", 32'(match_cnt), 32'd0);
        #1 rst = 1'b0;
        seq("arst_pat", 4, 16'h000D, 32'h00004321);

        // Length clamping.
        load(4'b0001, 3'd0, 1'b1);
        seq("len0", 2, 16'h0003, 32'h00000011);
        load(4'b1101, 3'd7, 1'b1);
        seq("len7", 4, 16'h000D, 32'h00004321);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_load = 1'b1; cfg_pat = 4'($urandom);
                cfg_len = 3'($urandom_range(0, 7)); cfg_overlap = 1'($urandom);
            end
            if ($urandom_range(0, 49) == 0) cnt_clr = 1'b1;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom));
        end

        // Saturation, then clear on an accepting edge.
        load(4'b0011, 3'd2, 1'b1);
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        for (int i = 0; i < 270; i++) step(1'b1, 1'b1);
        check("sat_cnt", 32'(match_cnt), CNT_EN ? 32'd255 : 32'd0);
        check("sat_cnt_w2", 32'(match_cnt2), CNT_EN ? 32'd3 : 32'd0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        check("clr_accept", 32'(match_cnt), 32'd0);
        check("clr_accept_match", 32'(match), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
